// File: rtl/voice_allocator_if.sv
// Note-event handshake bus for the voice allocator.
// The event source drives the master side and the allocator is the slave.
interface voice_allocator_if;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_on;
    logic [3:0] note;
    logic [2:0] octave;

    modport master (output ev_valid, output ev_on, output note, output octave, input ev_ready);
    modport slave  (input ev_valid, input ev_on, input note, input octave, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note events to voice slots with LRU age ranks.
// Define VOICE_STEAL_EN to steal the oldest voice instead of dropping when all voices are held.
module voice_allocator #(
    parameter int NUM_VOICES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    voice_allocator_if.slave          ev,
    input  logic                      all_off,
    output logic [NUM_VOICES-1:0]     voice_ld,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [4*NUM_VOICES-1:0]   voice_note,
    output logic [3*NUM_VOICES-1:0]   voice_octave,
    output logic                      ev_dropped,
    output logic [7:0]                steal_count
);

    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic {IDLE, ALLOC} state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic                  r_evOn;
    logic [3:0]            r_evNote;
    logic [2:0]            r_evOct;
    logic [NUM_VOICES-1:0] r_ld;
    logic [NUM_VOICES-1:0] r_gate;
    logic                  r_dropped;
    logic [3:0]            r_note [NUM_VOICES];
    logic [2:0]            r_oct  [NUM_VOICES];
    logic [IW-1:0]         r_age  [NUM_VOICES];

    logic                  w_matchFound;
    logic [IW-1:0]         w_matchIdx;
    logic                  w_freeFound;
    logic [IW-1:0]         w_freeIdx;
    logic                  w_touch;
    logic                  w_load;
    logic                  w_clear;
    logic                  w_drop;
    logic [IW-1:0]         w_target;
`ifdef VOICE_STEAL_EN
    logic [IW-1:0]         w_oldestIdx;
    logic                  w_steal;
    logic [7:0]            r_stealCount;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        ev.ev_ready = 1'b0;
        case (r_state)
            IDLE: begin
                ev.ev_ready = 1'b1;
                if (ev.ev_valid && !all_off) begin
                    w_nextState = ALLOC;
                end
            end
            ALLOC:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (all_off) begin
            w_nextState = IDLE;
        end
    end

    // Descending scan so the lowest matching/free index wins.
    always_comb begin
        w_matchFound = 1'b0;
        w_matchIdx   = '0;
        w_freeFound  = 1'b0;
        w_freeIdx    = '0;
`ifdef VOICE_STEAL_EN
        w_oldestIdx  = '0;
`endif
        for (int k = NUM_VOICES - 1; k >= 0; k--) begin
            if (r_gate[k] && (r_note[k] == r_evNote) && (r_oct[k] == r_evOct)) begin
                w_matchFound = 1'b1;
                w_matchIdx   = IW'(k);
            end
            if (!r_gate[k]) begin
                w_freeFound = 1'b1;
                w_freeIdx   = IW'(k);
            end
`ifdef VOICE_STEAL_EN
            if (r_age[k] == IW'(NUM_VOICES - 1)) begin
                w_oldestIdx = IW'(k);
            end
`endif
        end
    end

    always_comb begin
        w_touch  = 1'b0;
        w_load   = 1'b0;
        w_clear  = 1'b0;
        w_drop   = 1'b0;
        w_target = '0;
`ifdef VOICE_STEAL_EN
        w_steal  = 1'b0;
`endif
        if (r_state == ALLOC) begin
            if (r_evOn) begin
                if (w_matchFound) begin
                    w_touch  = 1'b1;
                    w_target = w_matchIdx;
                end else if (w_freeFound) begin
                    w_touch  = 1'b1;
                    w_load   = 1'b1;
                    w_target = w_freeIdx;
                end else begin
`ifdef VOICE_STEAL_EN
                    w_touch  = 1'b1;
                    w_load   = 1'b1;
                    w_steal  = 1'b1;
                    w_target = w_oldestIdx;
`else
                    w_drop   = 1'b1;
`endif
                end
            end else if (w_matchFound) begin
                w_clear  = 1'b1;
                w_target = w_matchIdx;
            end
        end
    end

    // all_off wins over both a pending decision and a same-edge capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evOn    <= 1'b0;
            r_evNote  <= '0;
            r_evOct   <= '0;
            r_ld      <= '0;
            r_gate    <= '0;
            r_dropped <= 1'b0;
            for (int k = 0; k < NUM_VOICES; k++) begin
                r_note[k] <= '0;
                r_oct[k]  <= '0;
                r_age[k]  <= IW'(k);
            end
`ifdef VOICE_STEAL_EN
            r_stealCount <= '0;
`endif
        end else if (all_off) begin
            r_gate    <= '0;
            r_ld      <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_ld      <= '0;
            r_dropped <= w_drop;
            if ((r_state == IDLE) && ev.ev_valid) begin
                r_evOn   <= ev.ev_on;
                r_evNote <= ev.note;
                r_evOct  <= ev.octave;
            end
            if (w_touch) begin
                r_ld[w_target] <= 1'b1;
                for (int j = 0; j < NUM_VOICES; j++) begin
                    if (IW'(j) == w_target) begin
                        r_age[j] <= '0;
                    end else if (r_age[j] < r_age[w_target]) begin
                        r_age[j] <= r_age[j] + 1'b1;
                    end
                end
            end
            if (w_load) begin
                r_note[w_target] <= r_evNote;
                r_oct[w_target]  <= r_evOct;
                r_gate[w_target] <= 1'b1;
            end
            if (w_clear) begin
                r_gate[w_target] <= 1'b0;
            end
`ifdef VOICE_STEAL_EN
            if (w_steal && (r_stealCount != 8'hFF)) begin
                r_stealCount <= r_stealCount + 8'd1;
            end
`endif
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_flat
        assign voice_note[4*g +: 4]   = r_note[g];
        assign voice_octave[3*g +: 3] = r_oct[g];
    end

    assign voice_ld   = r_ld;
    assign voice_gate = r_gate;
    assign ev_dropped = r_dropped;
`ifdef VOICE_STEAL_EN
    assign steal_count = r_stealCount;
`else
    assign steal_count = 8'd0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (NUM_VOICES=4).
// Expected values follow whether VOICE_STEAL_EN is defined for the build.
module tb_voice_allocator;

`ifdef VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        all_off;
    logic [3:0]  voice_ld;
    logic [3:0]  voice_gate;
    logic [15:0] voice_note;
    logic [11:0] voice_octave;
    logic        ev_dropped;
    logic [7:0]  steal_count;

    int checkCount = 0;
    int errorCount = 0;

    logic [15:0] expNote;

    voice_allocator_if evBus ();

    voice_allocator #(.NUM_VOICES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ev           (evBus),
        .all_off      (all_off),
        .voice_ld     (voice_ld),
        .voice_gate   (voice_gate),
        .voice_note   (voice_note),
        .voice_octave (voice_octave),
        .ev_dropped   (ev_dropped),
        .steal_count  (steal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Leaves time at #1 after the decision edge, i.e. inside the pulse cycle.
    task automatic applyStimulus(input logic on, input logic [3:0] n, input logic [2:0] o);
        int waitCycles = 0;
        @(negedge clk);
        while (!evBus.ev_ready && waitCycles < 8) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!evBus.ev_ready) begin
            checkOutput("readyTimeout", 32'(evBus.ev_ready), 32'd1);
        end
        evBus.ev_valid = 1'b1;
        evBus.ev_on    = on;
        evBus.note     = n;
        evBus.octave   = o;
        @(posedge clk);
        #1;
        evBus.ev_valid = 1'b0;
        checkOutput("busyAfterAccept", 32'(evBus.ev_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        all_off        = 1'b0;
        evBus.ev_valid = 1'b0;
        evBus.ev_on    = 1'b0;
        evBus.note     = '0;
        evBus.octave   = '0;
        #12;
        checkOutput("rstGate",   32'(voice_gate),   32'h0);
        checkOutput("rstLd",     32'(voice_ld),     32'h0);
        checkOutput("rstNote",   32'(voice_note),   32'h0);
        checkOutput("rstOct",    32'(voice_octave), 32'h0);
        checkOutput("rstDrop",   32'(ev_dropped),   32'h0);
        checkOutput("rstSteal",  32'(steal_count),  32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("readyAfterReset", 32'(evBus.ev_ready), 32'd1);

        applyStimulus(1'b1, 4'd0, 3'd4);
        checkOutput("firstLd",   32'(voice_ld),          32'b0001);
        checkOutput("firstGate", 32'(voice_gate),        32'b0001);
        checkOutput("firstNote", 32'(voice_note[3:0]),   32'd0);
        checkOutput("firstOct",  32'(voice_octave[2:0]), 32'd4);
        @(posedge clk);
        #1;
        checkOutput("ldOneCycle", 32'(voice_ld), 32'h0);

        applyStimulus(1'b1, 4'd2, 3'd4);
        applyStimulus(1'b1, 4'd4, 3'd4);
        applyStimulus(1'b1, 4'd5, 3'd4);
        checkOutput("fillLd",   32'(voice_ld),     32'b1000);
        checkOutput("fillGate", 32'(voice_gate),   32'b1111);
        checkOutput("fillNote", 32'(voice_note),   32'h5420);
        checkOutput("fillOct",  32'(voice_octave), 32'h924);

        applyStimulus(1'b0, 4'd2, 3'd4);
        checkOutput("offLd",   32'(voice_ld),   32'h0);
        checkOutput("offGate", 32'(voice_gate), 32'b1101);
        checkOutput("offDrop", 32'(ev_dropped), 32'h0);

        applyStimulus(1'b1, 4'd7, 3'd4);
        checkOutput("reuseLd",   32'(voice_ld),   32'b0010);
        checkOutput("reuseGate", 32'(voice_gate), 32'b1111);
        checkOutput("reuseNote", 32'(voice_note), 32'h5470);

        // Ages now: v1=0, v3=1, v2=2, v0=3.
        applyStimulus(1'b1, 4'd9, 3'd4);
        checkOutput("fullLd",    32'(voice_ld),    STEAL ? 32'b0001 : 32'h0);
        checkOutput("fullDrop",  32'(ev_dropped),  STEAL ? 32'h0 : 32'h1);
        checkOutput("fullNote",  32'(voice_note),  STEAL ? 32'h5479 : 32'h5470);
        checkOutput("fullSteal", 32'(steal_count), STEAL ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        checkOutput("dropOneCycle", 32'(ev_dropped), 32'h0);

        applyStimulus(1'b1, 4'd4, 3'd4);
        checkOutput("retrigLd",   32'(voice_ld),   32'b0100);
        checkOutput("retrigGate", 32'(voice_gate), 32'b1111);
        checkOutput("retrigNote", 32'(voice_note), STEAL ? 32'h5479 : 32'h5470);

        // Oldest is v3 when stealing (v2 retrigger aged everyone else).
        applyStimulus(1'b1, 4'd10, 3'd4);
        checkOutput("ageLd",    32'(voice_ld),    STEAL ? 32'b1000 : 32'h0);
        checkOutput("ageDrop",  32'(ev_dropped),  STEAL ? 32'h0 : 32'h1);
        checkOutput("ageNote",  32'(voice_note),  STEAL ? 32'hA479 : 32'h5470);
        checkOutput("ageSteal", 32'(steal_count), STEAL ? 32'd2 : 32'd0);
        expNote = voice_note;

        applyStimulus(1'b0, 4'd11, 3'd2);
        checkOutput("strayLd",   32'(voice_ld),   32'h0);
        checkOutput("strayDrop", 32'(ev_dropped), 32'h0);
        checkOutput("strayGate", 32'(voice_gate), 32'b1111);
        checkOutput("strayNote", 32'(voice_note), 32'(STEAL ? 16'hA479 : 16'h5470));

        applyStimulus(1'b0, 4'd4, 3'd4);
        checkOutput("holdGate", 32'(voice_gate), 32'b1011);
        checkOutput("holdNote", 32'(voice_note), 32'(expNote));
        checkOutput("holdLd",   32'(voice_ld),   32'h0);

        @(negedge clk);
        evBus.ev_valid = 1'b1;
        evBus.ev_on    = 1'b1;
        evBus.note     = 4'd12;
        evBus.octave   = 3'd1;
        @(posedge clk);
        #1;
        evBus.ev_valid = 1'b0;
        all_off = 1'b1;
        @(posedge clk);
        #1;
        all_off = 1'b0;
        checkOutput("panicGate",  32'(voice_gate),       32'h0);
        checkOutput("panicLd",    32'(voice_ld),         32'h0);
        checkOutput("panicDrop",  32'(ev_dropped),       32'h0);
        checkOutput("panicReady", 32'(evBus.ev_ready),   32'd1);
        checkOutput("panicNote",  32'(voice_note),       32'(expNote));
        @(posedge clk);
        #1;
        checkOutput("panicNoLd",  32'(voice_ld),         32'h0);

        applyStimulus(1'b1, 4'd3, 3'd1);
        checkOutput("afterPanicLd",   32'(voice_ld),   32'b0001);
        checkOutput("afterPanicGate", 32'(voice_gate), 32'b0001);
        checkOutput("afterPanicNote", 32'(voice_note), 32'({expNote[15:4], 4'h3}));

        @(negedge clk);
        evBus.ev_valid = 1'b1;
        evBus.note     = 4'd6;
        all_off        = 1'b1;
        @(posedge clk);
        #1;
        evBus.ev_valid = 1'b0;
        all_off        = 1'b0;
        checkOutput("allOffBeatsAccept", 32'(evBus.ev_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("allOffNoLd",   32'(voice_ld),   32'h0);
        checkOutput("allOffGate",   32'(voice_gate), 32'h0);

        @(negedge clk);
        evBus.ev_valid = 1'b1;
        evBus.ev_on    = 1'b1;
        evBus.note     = 4'd8;
        evBus.octave   = 3'd2;
        @(posedge clk);
        #1;
        evBus.ev_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midRstGate",  32'(voice_gate),     32'h0);
        checkOutput("midRstNote",  32'(voice_note),     32'h0);
        checkOutput("midRstOct",   32'(voice_octave),   32'h0);
        checkOutput("midRstReady", 32'(evBus.ev_ready), 32'd1);
        checkOutput("midRstSteal", 32'(steal_count),    32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midRstNoLd",  32'(voice_ld),       32'h0);
        checkOutput("midRstIdle",  32'(evBus.ev_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of voice slots (legal 2..8).
REQ-002 SHALL have port clk  in  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ev_valid  in  1  note event present.
REQ-005 SHALL have port ev_ready  out  1  allocator can accept event.
REQ-006 SHALL have port ev_on  in  1  1 = note-on, 0 = note-off.
REQ-007 SHALL have port note  in  4  note value of event.
REQ-008 SHALL have port octave  in  3  octave of event.
REQ-009 SHALL have port all_off  in  1  panic: release every voice.
REQ-010 SHALL have port voice_ld  out  NUM_VOICES  one-cycle load pulse per voice.
REQ-011 SHALL have port voice_gate  out  NUM_VOICES  per-voice held-note flag.
REQ-012 SHALL have port voice_note  out  4*NUM_VOICES  note of voice k at bits [4k+3:4k].
REQ-013 SHALL have port voice_octave  out  3*NUM_VOICES  octave of voice k at bits [3k+2:3k].
REQ-014 SHALL have port ev_dropped  out  1  one-cycle pulse: note-on discarded.
REQ-015 SHALL have port steal_count  out  8  saturating count of stolen voices.

Function
REQ-016 SHALL implement FSM states IDLE and ALLOC; ev_ready = 1 only in IDLE.
REQ-017 SHALL capture ev_on/note/octave and move IDLE->ALLOC on an edge where ev_valid && ev_ready; ALLOC->IDLE unconditionally on the next edge.
REQ-018 SHALL apply the allocation decision on the ALLOC->IDLE edge; voice_ld/ev_dropped pulses are high for exactly the cycle after that edge (latency 2 edges from acceptance; max throughput 1 event per 2 cycles).
REQ-019 Note-on, priority 1: voice with gate=1 and matching note+octave -> retrigger: voice_ld[k]=1, gate stays 1, no reassignment.
REQ-020 Note-on, priority 2: lowest-index voice with gate=0 -> load note/octave, gate<=1, voice_ld[k]=1.
REQ-021 Note-on, all gates 1, no match: handled per REQ-031/REQ-032.
REQ-022 Note-off: lowest-index gated voice matching note+octave -> gate<=0, no voice_ld pulse; no match -> no state change, no pulse.
REQ-023 SHALL keep per-voice age ranks forming a permutation of 0..NUM_VOICES-1 (0 = newest); on any note-on load/retrigger of voice k, voices with age < age[k] increment and age[k]<=0; note-off leaves ages unchanged.
REQ-024 Oldest voice = age NUM_VOICES-1.
REQ-025 voice_note/voice_octave SHALL hold last loaded values after gate clears.
REQ-026 all_off sampled high at an edge: all gates <= 0, FSM <= IDLE, any pending ALLOC event discarded (no voice_ld, no ev_dropped, ages unchanged); all_off takes priority over simultaneous acceptance (ev_ready still 1 in IDLE but no event is captured that edge).
REQ-027 steal_count SHALL saturate at 255.

Reset
REQ-028 On reset asserted: FSM=IDLE, voice_ld=0, voice_gate=0, voice_note=0, voice_octave=0, ev_dropped=0, steal_count=0, age[k]=k.
REQ-029 Reset mid-ALLOC SHALL discard the pending event with no output pulse.
REQ-030 ev_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-031 With VOICE_STEAL_EN defined: full-no-match note-on steals oldest voice (load, gate stays 1, voice_ld pulse, age update, steal_count+1); ev_dropped never asserts.
REQ-032 Without VOICE_STEAL_EN: full-no-match note-on changes no state, ev_dropped pulses one cycle, steal_count stays 0.

Verification (NUM_VOICES=4)
REQ-033 Reset, then note-on (C=0,oct 4) accepted at edge 1 -> voice_ld=4'b0001 after edge 2, voice_gate=0001, voice_note[3:0]=0, voice_octave[2:0]=4, ev_ready low between edges 1 and 2.
REQ-034 Note-ons 0,2,4,5 (oct 4) then note-off 2 -> gate=1101; next note-on 7 -> voice 1 loaded, gate=1111.
REQ-035 Four voices full (notes 0,2,4,5), note-on 9 -> with VOICE_STEAL_EN voice 0 reloaded with 9, steal_count=1; without, ev_dropped pulse, outputs unchanged.
REQ-036 Note-on 4 oct 4 while voice 2 already holds it -> voice_ld=0100, gate unchanged, voice 2 age becomes 0.
REQ-037 all_off asserted the edge after acceptance (during ALLOC) -> gate=0000, no voice_ld, ev_ready=1 next cycle; async reset mid-ALLOC -> all outputs at reset values immediately.
REQ-038 Note-off for note not held (11, oct 2) -> no output change, no pulse.
